// File: rtl/sdram_rd_buffer.sv
// Read-side FIFO between the SDRAM read engine and the consumer, with a burst-trigger FSM.
// Define RD_BUF_FWFT_EN for first-word-fall-through output; otherwise pops have one-cycle latency.
module sdram_rd_buffer #(
    parameter int DATA_W      = 16,
    parameter int AW          = 10,
    parameter int BURST_WORDS = 256
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              trig_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_trig,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              ovf,
    output logic              udf
);
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BURST_L   = (AW+1)'(BURST_WORDS);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BURST_WORDS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TRIG = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       free_words;
    logic              wr_acc;
    logic              rd_acc;
    logic [1:0]        state;
    logic [CW-1:0]     rx_cnt;

    // Flags come from registered pointers, so accept decisions use pre-edge state.
    assign level      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_acc     = wr_en & ~full;
    assign rd_acc     = rd_en & ~empty;
    assign free_words = DEPTH_L - level;

    // NOTE: the storage array is deliberately not reset; the pointers alone define its contents.
    always_ff @(posedge sclk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_en && full)  ovf <= 1'b1;
            if (rd_en && empty) udf <= 1'b1;
        end
    end

    // rd_trig is high exactly while the FSM sits in TRIG; every word seen in FILL counts, dropped or not.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state   <= IDLE;
            rx_cnt  <= '0;
            rd_trig <= 1'b0;
        end else begin
            rd_trig <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_en && (free_words >= BURST_L)) begin
                        state   <= TRIG;
                        rd_trig <= 1'b1;
                    end
                end
                TRIG: begin
                    rx_cnt <= '0;
                    state  <= FILL;
                end
                FILL: begin
                    if (wr_en) begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                        if (rx_cnt == CNT_LAST) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RD_BUF_FWFT_EN
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sdram_rd_buffer.sv
// Self-checking bench for sdram_rd_buffer: vector table plus directed multi-cycle sequences.
module tb_sdram_rd_buffer;
    localparam int DATA_W      = 16;
    localparam int AW          = 10;
    localparam int BURST_WORDS = 256;
    localparam int DEPTH       = 1024;

    logic              sclk = 1'b0;
    logic              s_rst;
    logic              trig_en;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_trig;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [AW:0]       level;
    logic              ovf;
    logic              udf;

    int n_checks  = 0;
    int n_errors  = 0;
    int trig_seen = 0;
    int n_popped  = 0;
    int trig_base;
    int pop_base;
    logic [DATA_W-1:0] model_q[$];

    typedef struct {
        logic              w;
        logic [DATA_W-1:0] d;
        logic              r;
        logic [AW:0]       lvl;
        logic              emp;
        logic              ful;
        logic              udf_e;
        logic              vld;
        logic [DATA_W-1:0] dat;
    } vec_t;

    vec_t vecs[10];

    sdram_rd_buffer #(
        .DATA_W     (DATA_W),
        .AW         (AW),
        .BURST_WORDS(BURST_WORDS)
    ) dut (
        .sclk    (sclk),
        .s_rst   (s_rst),
        .trig_en (trig_en),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_trig (rd_trig),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .empty   (empty),
        .full    (full),
        .level   (level),
        .ovf     (ovf),
        .udf     (udf)
    );

    always #5 sclk = ~sclk;

    // Counts cycles during which rd_trig was high (pre-edge value).
    always @(posedge sclk) begin
        if (rd_trig === 1'b1) trig_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // One cycle of traffic checked against a queue model of the FIFO.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r);
        logic              wa;
        logic              ra;
        logic [DATA_W-1:0] exp_d;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        wa      = w && (model_q.size() < DEPTH);
        ra      = r && (model_q.size() > 0);
        exp_d   = ra ? model_q[0] : '0;
`ifdef RD_BUF_FWFT_EN
        if (ra) check("fwft_head", rd_data, exp_d);
`endif
        tick();
        if (ra) begin
            exp_d = model_q.pop_front();
            n_popped++;
        end
        if (wa) model_q.push_back(d);
`ifndef RD_BUF_FWFT_EN
        if (ra) begin
            check("pop_valid", rd_valid, 1);
            check("pop_data", rd_data, exp_d);
        end
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input logic te);
        s_rst   = 1'b1;
        trig_en = te;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        tick();
        tick();
        s_rst = 1'b0;
        model_q.delete();
    endtask

    task automatic wait_trig(input string name);
        int k = 0;
        while (rd_trig !== 1'b1 && k < 600) begin
            tick();
            k++;
        end
        check(name, rd_trig, 1);
    endtask

    task automatic burst(input int base, input string name);
        wait_trig(name);
        tick();
        for (int i = 0; i < BURST_WORDS; i++) step(1'b1, DATA_W'(base + i), 1'b0);
    endtask

    initial begin
        //              w     d         r     lvl    emp   ful   udf   vld   dat
        vecs[0] = '{1'b0, 16'h0000, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 16'h1111, 1'b0, 11'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 16'h2222, 1'b0, 11'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 11'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111};
        vecs[5] = '{1'b1, 16'h3333, 1'b1, 11'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 11'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2222};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3333};
        vecs[8] = '{1'b1, 16'h4444, 1'b1, 11'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3333};
        vecs[9] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4444};

        // Basic FIFO behaviour with triggering disabled.
        do_reset(1'b0);
        foreach (vecs[i]) begin
            wr_en   = vecs[i].w;
            wr_data = vecs[i].d;
            rd_en   = vecs[i].r;
            tick();
            check($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].emp);
            check($sformatf("vec%0d_full", i), full, vecs[i].ful);
            check($sformatf("vec%0d_udf", i), udf, vecs[i].udf_e);
            check($sformatf("vec%0d_ovf", i), ovf, 0);
            check($sformatf("vec%0d_trig", i), rd_trig, 0);
`ifndef RD_BUF_FWFT_EN
            check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].vld);
            check($sformatf("vec%0d_data", i), rd_data, vecs[i].dat);
`endif
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Trigger timing after reset and fill to full without popping.
        trig_base = trig_seen;
        do_reset(1'b1);
        check("rst_trig", rd_trig, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);
        check("rst_valid", rd_valid, 0);
        tick();
        check("trig1_pulse", rd_trig, 1);
        tick();
        check("trig1_single", rd_trig, 0);
        for (int i = 0; i < BURST_WORDS; i++) step(1'b1, DATA_W'(i), 1'b0);
        check("burst1_level", level, 256);
        check("burst1_trig_low", rd_trig, 0);
        tick();
        check("trig2_pulse", rd_trig, 1);
        burst(16'h0100, "trig2_wait");
        burst(16'h0200, "trig3_wait");
        burst(16'h0300, "trig4_wait");
        for (int i = 0; i < 20; i++) tick();
        check("fill_trig_count", trig_seen - trig_base, 4);
        check("fill_level", level, 1024);
        check("fill_full", full, 1);
        check("fill_ovf", ovf, 0);
        step(1'b1, 16'hDEAD, 1'b0);
        check("dead_ovf", ovf, 1);
        check("dead_level", level, 1024);
        for (int i = 0; i < 20; i++) tick();
        check("no_fifth_trig", trig_seen - trig_base, 4);

        // Full FIFO with simultaneous write and pop, then drain in order.
        trig_en = 1'b0;
        step(1'b1, 16'hBEEF, 1'b1);
        check("beef_level", level, 1023);
        check("beef_ovf", ovf, 1);
        check("beef_full", full, 0);
        while (model_q.size() > 0) step(1'b0, '0, 1'b1);
        check("drain_level", level, 0);
        check("drain_empty", empty, 1);

        // Streaming through the pointer wrap with concurrent pops.
        pop_base = n_popped;
        for (int i = 1; i <= 16'h0600; i++) step(1'b1, DATA_W'(i), (i > 3));
        while (model_q.size() > 0) step(1'b0, '0, 1'b1);
        check("wrap_pops", n_popped - pop_base, 16'h0600);
        check("wrap_level", level, 0);
        check("wrap_empty", empty, 1);

        // Underflow, then reset in the middle of a FILL.
        step(1'b0, '0, 1'b1);
        check("udf_set", udf, 1);
        check("udf_level", level, 0);
        check("udf_valid", rd_valid, 0);
        trig_en = 1'b1;
        wait_trig("trig_midfill");
        tick();
        for (int i = 0; i < 100; i++) step(1'b1, DATA_W'(16'hA000 + i), 1'b0);
        check("midfill_level", level, 100);
        s_rst   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'hA064;
        tick();
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_ovf", ovf, 0);
        check("midrst_udf", udf, 0);
        check("midrst_trig", rd_trig, 0);
        tick();
        check("midrst_trig_hold", rd_trig, 0);
        s_rst = 1'b0;
        model_q.delete();
        step(1'b1, 16'hA065, 1'b0);
        check("post_rst_trig", rd_trig, 1);
        check("post_rst_level", level, 1);
        step(1'b1, 16'hA066, 1'b0);
        check("post_rst_trig_low", rd_trig, 0);
        check("post_rst_level2", level, 2);
        while (model_q.size() > 0) step(1'b0, '0, 1'b1);
        check("post_rst_drained", empty, 1);

`ifdef RD_BUF_FWFT_EN
        check("fwft_empty_valid", rd_valid, 0);
        step(1'b1, 16'h5A5A, 1'b0);
        check("fwft_fall_data", rd_data, 16'h5A5A);
        check("fwft_fall_valid", rd_valid, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
